// File: rtl/sram_frame_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_frame_reader_pkg : shared FSM encoding and SRAM widths for the reader
// Rev 1.0
// ----------------------------------------------------------------------------
package sram_frame_reader_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_frame_reader_word_to_pixel_unpacker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// word_to_pixel_unpacker : one 32-bit word register emitted as 4 bytes, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
module word_to_pixel_unpacker
  import sram_frame_reader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SRAM_DATA_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [7:0]             pix,
  output logic                   pix_last
);

  logic [SRAM_DATA_W-1:0] word_q;
  logic [1:0]             idx_q;
  logic                   full_q;
  logic                   last_q;
  logic                   pix_hs;
  logic                   word_done;
  logic                   load;

  assign pix_hs    = full_q & pix_ready;
  assign word_done = pix_hs & (idx_q == 2'd3);
  // Refill in the same cycle the final byte leaves so words stream without bubbles.
  assign in_ready  = enable & (~full_q | word_done);
  assign load      = in_valid & in_ready;

  assign pix_valid = full_q;
  assign pix       = word_q[{idx_q, 3'b000} +: 8];
  assign pix_last  = full_q & last_q & (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= 2'd0;
      full_q <= 1'b0;
      last_q <= 1'b0;
    end else if (load) begin
      word_q <= in_data;
      last_q <= in_last;
      full_q <= 1'b1;
      idx_q  <= 2'd0;
    end else if (word_done) begin
      full_q <= 1'b0;
      idx_q  <= 2'd0;
    end else if (pix_hs) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_frame_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_frame_reader : credit-limited SRAM frame fetch feeding an 8-bit pixel stream
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int FRAME_WORDS     = 19200,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SRAM_ADDR_W-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_addr_valid,
  input  logic                   rd_addr_ready,
  output logic [SRAM_ADDR_W-1:0] rd_addr,
  input  logic                   rd_data_valid,
  output logic                   rd_data_ready,
  input  logic [SRAM_DATA_W-1:0] rd_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [7:0]             pix,
  output logic                   pix_last
);

  localparam int             CNT_W     = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
  localparam logic [3:0]     CREDITS   = 4'(MAX_OUTSTANDING);

  state_t                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]       issue_q;
  logic [CNT_W-1:0]       data_cnt_q;
  logic [3:0]             outstanding_q;
  logic                   addr_hs;
  logic                   data_hs;
  logic                   pix_hs;
  logic                   accept_start;

  assign addr_hs      = rd_addr_valid & rd_addr_ready;
  assign data_hs      = rd_data_valid & rd_data_ready;
  assign pix_hs       = pix_valid & pix_ready;
  assign accept_start = (state_q == IDLE) & start;

  // Valid only drops via handshake: outstanding can only fall while waiting.
  assign rd_addr_valid = (state_q == RUN) && (issue_q < FRAME_CNT) && (outstanding_q < CREDITS);
  assign rd_addr       = base_q + SRAM_ADDR_W'(issue_q);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DRAIN) & pix_hs & pix_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (addr_hs && (issue_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (pix_hs && pix_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q        <= '0;
      issue_q       <= '0;
      data_cnt_q    <= '0;
      outstanding_q <= 4'd0;
    end else if (accept_start) begin
      base_q        <= base_addr;
      issue_q       <= '0;
      data_cnt_q    <= '0;
      outstanding_q <= 4'd0;
    end else begin
      if (addr_hs) issue_q <= issue_q + CNT_W'(1);
      if (data_hs) data_cnt_q <= data_cnt_q + CNT_W'(1);
      case ({addr_hs, data_hs})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  word_to_pixel_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (busy),
    .in_valid  (rd_data_valid),
    .in_ready  (rd_data_ready),
    .in_data   (rd_data),
    .in_last   (data_cnt_q == LAST_IDX),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix       (pix),
    .pix_last  (pix_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_frame_reader : scoreboard bench with a memory model for sram_frame_reader
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sram_frame_reader;
  import sram_frame_reader_pkg::*;

  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic        busy, done, rd_addr_valid, rd_data_ready, pix_valid, pix_last;
  logic        rd_addr_ready = 1'b0, rd_data_valid = 1'b0, pix_ready = 1'b0;
  logic [17:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [7:0]  pix;

  logic        b_start = 1'b0;
  logic [17:0] b_base_addr = 18'h00200;
  logic        b_busy, b_done, b_rd_addr_valid, b_rd_data_ready, b_pix_valid, b_pix_last;
  logic        b_rd_addr_ready = 1'b0, b_rd_data_valid = 1'b0, b_pix_ready = 1'b0;
  logic [17:0] b_rd_addr;
  logic [31:0] b_rd_data = '0;
  logic [7:0]  b_pix;

  sram_frame_reader #(.FRAME_WORDS(FW), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix(pix), .pix_last(pix_last));

  sram_frame_reader #(.FRAME_WORDS(FW), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base_addr), .busy(b_busy), .done(b_done),
    .rd_addr_valid(b_rd_addr_valid), .rd_addr_ready(b_rd_addr_ready), .rd_addr(b_rd_addr),
    .rd_data_valid(b_rd_data_valid), .rd_data_ready(b_rd_data_ready), .rd_data(b_rd_data),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix(b_pix), .pix_last(b_pix_last));

  typedef struct packed { logic [7:0] b; logic last; } pix_exp_t;
  typedef struct { logic [17:0] base; int mode; bit toggle; logic [17:0] exp_last_addr; int exp_span; } vec_t;

  int checks = 0, failures = 0;
  logic [17:0] exp_addr_q[$];
  logic [17:0] mem_q[$];
  pix_exp_t    pix_q[$];
  int data_mode = 0, cyc = 0;
  bit toggle_mode = 0, start_req = 0, prev_wait = 0;
  logic [17:0] prev_addr = '0, last_addr = '0;
  int addr_hs_n = 0, data_hs_n = 0, pix_hs_n = 0, done_n = 0, first_cyc = 0, last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [17:0] a, input int mode);
    case (mode)
      0:       return 32'h44332211;
      1:       return {a[7:0] ^ 8'hA5, a[15:8], a[7:0] ^ 8'h3C, {6'd0, a[17:16]}};
      default: return {8'hC3 ^ a[7:0], a[7:0] + 8'd7, ~a[7:0], a[15:8]};
    endcase
  endfunction

  task automatic apply_inputs();
    start         = start_req;
    rd_addr_ready = toggle_mode ? (cyc % 3 != 0) : 1'b1;
    pix_ready     = toggle_mode ? cyc[0] : 1'b1;
    rd_data_valid = (mem_q.size() > 0);
    rd_data       = (mem_q.size() > 0) ? word_of(mem_q[0], data_mode) : 32'h0;
  endtask

  task automatic observe();
    logic ahs, dhs, phs, exp_ready, exp_done;
    logic [31:0] w;
    pix_exp_t e;
    ahs = rd_addr_valid & rd_addr_ready;
    dhs = rd_data_valid & rd_data_ready;
    phs = pix_valid & pix_ready;
    exp_ready = busy && (!pix_valid || (pix_ready && pix_q.size() == 1));
    exp_done  = phs && (pix_q.size() > 0) && pix_q[0].last;
    check("rd_data_ready", {31'd0, rd_data_ready}, {31'd0, exp_ready});
    check("pix_valid", {31'd0, pix_valid}, {31'd0, pix_q.size() != 0});
    check("done", {31'd0, done}, {31'd0, exp_done});
    if (prev_wait) check("rd_addr_stable", {14'd0, rd_addr}, {14'd0, prev_addr});
    prev_wait = rd_addr_valid && !ahs;
    prev_addr = rd_addr;
    if (start && !busy) begin
      for (int i = 0; i < FW; i++) exp_addr_q.push_back(base_addr + 18'(i));
      addr_hs_n = 0; data_hs_n = 0; pix_hs_n = 0; done_n = 0;
    end
    if (ahs) begin
      if (exp_addr_q.size() == 0) check("rd_addr_extra", {14'd0, rd_addr}, 32'hFFFF_FFFF);
      else check("rd_addr", {14'd0, rd_addr}, {14'd0, exp_addr_q.pop_front()});
      mem_q.push_back(rd_addr);
      if (addr_hs_n == 0) first_cyc = cyc;
      last_cyc  = cyc;
      last_addr = rd_addr;
      addr_hs_n++;
    end
    if (dhs) begin
      w = word_of(mem_q.pop_front(), data_mode);
      for (int b = 0; b < 4; b++) pix_q.push_back({w[8*b +: 8], (data_hs_n == FW-1) && (b == 3)});
      data_hs_n++;
    end
    if (phs) begin
      if (pix_q.size() == 0) check("pix_extra", {24'd0, pix}, 32'hFFFF_FFFF);
      else begin
        e = pix_q.pop_front();
        check("pix", {24'd0, pix}, {24'd0, e.b});
        check("pix_last", {31'd0, pix_last}, {31'd0, e.last});
      end
      pix_hs_n++;
    end
    if (done) done_n++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    apply_inputs();
    #1;
    observe();
  endtask

  task automatic run_frame(input logic [17:0] base, input int mode, input bit tog, input int restart_at);
    data_mode   = mode;
    toggle_mode = tog;
    base_addr   = base;
    start_req   = 1'b1;
    tick();
    start_req   = 1'b0;
    for (int n = 0; n < 400 && done_n == 0; n++) begin
      tick();
      if (n == restart_at) begin start_req = 1'b1; base_addr = 18'h3F000; end
      else start_req = 1'b0;
    end
    start_req = 1'b0;
    repeat (6) tick();
    check("done_count", done_n, 1);
    check("addr_hs_count", addr_hs_n, FW);
    check("pix_count", pix_hs_n, 4*FW);
    check("pix_q_empty", pix_q.size(), 0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_rd_addr_valid"}, {31'd0, rd_addr_valid}, 0);
    check({tag, "_rd_data_ready"}, {31'd0, rd_data_ready}, 0);
    check({tag, "_pix_valid"}, {31'd0, pix_valid}, 0);
    check({tag, "_rd_addr"}, {14'd0, rd_addr}, 0);
    check({tag, "_pix"}, {24'd0, pix}, 0);
  endtask

  initial begin
    vec_t vecs[4];
    int b_hs;
    vecs[0] = '{base: 18'h00010, mode: 0, toggle: 1'b0, exp_last_addr: 18'h00013, exp_span: 3};
    vecs[1] = '{base: 18'h3FFFE, mode: 1, toggle: 1'b0, exp_last_addr: 18'h00001, exp_span: 3};
    vecs[2] = '{base: 18'h01234, mode: 1, toggle: 1'b1, exp_last_addr: 18'h01237, exp_span: -1};
    vecs[3] = '{base: 18'h20000, mode: 2, toggle: 1'b1, exp_last_addr: 18'h20003, exp_span: -1};

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Credit limit: two requests, no data back, then one word frees a credit.
    @(posedge clk); #1;
    b_rd_addr_ready = 1'b1; b_pix_ready = 1'b1; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_hs = 0;
    repeat (20) begin
      #1;
      if (b_rd_addr_valid && b_rd_addr_ready) begin
        check("b_rd_addr", {14'd0, b_rd_addr}, {14'd0, 18'h00200 + 18'(b_hs)});
        b_hs++;
      end
      @(posedge clk); #1;
    end
    check("b_addr_hs_count", b_hs, 2);
    check("b_addr_valid_held_low", {31'd0, b_rd_addr_valid}, 0);
    b_rd_data_valid = 1'b1; b_rd_data = 32'hA1B2C3D4;
    #1;
    check("b_rd_data_ready", {31'd0, b_rd_data_ready}, 1);
    @(posedge clk); #1;
    b_rd_data_valid = 1'b0;
    #1;
    check("b_addr_valid_after_data", {31'd0, b_rd_addr_valid}, 1);
    check("b_rd_addr_next", {14'd0, b_rd_addr}, {14'd0, 18'h00202});
    check("b_pix_valid", {31'd0, b_pix_valid}, 1);
    check("b_pix_first", {24'd0, b_pix}, 32'hD4);

    foreach (vecs[i]) begin
      run_frame(vecs[i].base, vecs[i].mode, vecs[i].toggle, -1);
      check("last_addr", {14'd0, last_addr}, {14'd0, vecs[i].exp_last_addr});
      if (vecs[i].exp_span >= 0) check("addr_span", last_cyc - first_cyc, vecs[i].exp_span);
    end

    // Start re-pulsed mid-frame with a different base must be ignored.
    run_frame(18'h00040, 2, 1'b1, 3);
    check("restart_last_addr", {14'd0, last_addr}, {14'd0, 18'h00043});

    // Reset mid-frame after two delivered words, then a clean full frame.
    data_mode = 1; toggle_mode = 1'b0; base_addr = 18'h00100; start_req = 1'b1;
    tick();
    start_req = 1'b0;
    for (int n = 0; n < 100 && data_hs_n < 2; n++) tick();
    check("two_words_before_reset", data_hs_n, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_addr_q.delete(); mem_q.delete(); pix_q.delete();
    rd_data_valid = 1'b0; prev_wait = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_frame(18'h00100, 1, 1'b0, -1);
    check("post_reset_last_addr", {14'd0, last_addr}, {14'd0, 18'h00103});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
